// File: rtl/fetch_unit.sv
// Instruction prefetch stage: streams program bytes into a small queue and
// exposes a 3-byte window at the instruction PC. Optional macro FETCH_FLUSH_STATS_EN.
module fetch_unit #(
    parameter int          DEPTH    = 4,
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        mem_req,
    output logic [15:0] mem_addr,
    input  logic [7:0]  mem_rdata,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    input  logic [1:0]  take_len,
    output logic [15:0] win_pc,
    output logic [7:0]  win_b0,
    output logic [7:0]  win_b1,
    output logic [7:0]  win_b2,
    output logic [1:0]  win_count,
    output logic        take_err,
    output logic [15:0] flushed
);

    typedef logic [15:0] addr_t;
    typedef logic [7:0]  data_t;

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    data_t         q [DEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [CW-1:0] count;
    logic          inflight;
    addr_t         fetch_pc;

    logic          take_ok;
    logic          append;
    logic [1:0]    pop;

    function automatic logic [PW-1:0] ptr_add(input logic [PW-1:0] p, input logic [1:0] n);
        int s;
        s = int'(p) + int'(n);
        if (s >= DEPTH) s = s - DEPTH;
        return PW'(s);
    endfunction

    // Issue ignores the same-cycle take, so an in-flight byte always has room.
    always_comb begin
        mem_req  = !reset && !redirect && ((int'(count) + int'(inflight)) < DEPTH);
        mem_addr = fetch_pc;
    end

    always_comb begin
        win_count = (count >= CW'(3)) ? 2'd3 : count[1:0];
        win_b0    = (count >= CW'(1)) ? q[head] : 8'h00;
        win_b1    = (count >= CW'(2)) ? q[ptr_add(head, 2'd1)] : 8'h00;
        win_b2    = (count >= CW'(3)) ? q[ptr_add(head, 2'd2)] : 8'h00;
        take_ok   = (take_len <= win_count);
        append    = inflight && !redirect;
        pop       = (!redirect && take_ok) ? take_len : 2'd0;
    end

    always_ff @(posedge clk) begin
        if (append) q[tail] <= mem_rdata;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            inflight <= 1'b0;
            fetch_pc <= RESET_PC;
            win_pc   <= RESET_PC;
            take_err <= 1'b0;
        end else if (redirect) begin
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            inflight <= 1'b0;
            fetch_pc <= redirect_pc;
            win_pc   <= redirect_pc;
            take_err <= 1'b0;
        end else begin
            if (append) tail <= ptr_add(tail, 2'd1);
            head     <= ptr_add(head, pop);
            count    <= count + CW'(append) - CW'(pop);
            inflight <= mem_req;
            fetch_pc <= fetch_pc + 16'(mem_req);
            win_pc   <= win_pc + 16'(pop);
            take_err <= !take_ok;
        end
    end

`ifdef FETCH_FLUSH_STATS_EN
    addr_t       flushed_r;
    logic [16:0] flush_sum;

    // Discarded bytes are the queued ones plus any byte returning in the redirect cycle.
    assign flush_sum = {1'b0, flushed_r} + 17'(count) + 17'(inflight);

    always_ff @(posedge clk) begin
        if (reset) begin
            flushed_r <= '0;
        end else if (redirect) begin
            flushed_r <= flush_sum[16] ? 16'hFFFF : flush_sum[15:0];
        end
    end

    assign flushed = flushed_r;
`else
    assign flushed = 16'h0000;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Testbench for fetch_unit: vector table, directed corner sequences and a
// randomized run against a queue-based reference model.
module tb_fetch_unit;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic [1:0]  take_len;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic [7:0]  mem_rdata;
    logic [15:0] win_pc;
    logic [7:0]  win_b0, win_b1, win_b2;
    logic [1:0]  win_count;
    logic        take_err;
    logic [15:0] flushed;

    logic [1:0]  take_len2;
    logic        mem_req2;
    logic [15:0] mem_addr2;
    logic [7:0]  mem_rdata2;
    logic [15:0] win_pc2;
    logic [7:0]  win2_b0, win2_b1, win2_b2;
    logic [1:0]  win_count2;
    logic        take_err2;
    logic [15:0] flushed2;

    logic [7:0]  mem [0:65535];

    fetch_unit #(.DEPTH(DEPTH), .RESET_PC(16'h0000)) dut (
        .clk(clk), .reset(reset), .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_rdata(mem_rdata), .redirect(redirect), .redirect_pc(redirect_pc),
        .take_len(take_len), .win_pc(win_pc), .win_b0(win_b0), .win_b1(win_b1),
        .win_b2(win_b2), .win_count(win_count), .take_err(take_err), .flushed(flushed)
    );

    fetch_unit #(.DEPTH(DEPTH), .RESET_PC(16'hFFFE)) dut2 (
        .clk(clk), .reset(reset), .mem_req(mem_req2), .mem_addr(mem_addr2),
        .mem_rdata(mem_rdata2), .redirect(1'b0), .redirect_pc(16'h0000),
        .take_len(take_len2), .win_pc(win_pc2), .win_b0(win2_b0), .win_b1(win2_b1),
        .win_b2(win2_b2), .win_count(win_count2), .take_err(take_err2), .flushed(flushed2)
    );

    function automatic logic [7:0] img2(input logic [15:0] a);
        case (a)
            16'hFFFE: return 8'h11;
            16'hFFFF: return 8'h22;
            16'h0000: return 8'h33;
            default:  return a[7:0] ^ 8'h5A;
        endcase
    endfunction

    // Synchronous program memories with one cycle of read latency.
    always @(posedge clk) begin
        mem_rdata  <= mem[mem_addr];
        mem_rdata2 <= img2(mem_addr2);
    end

    // Reference model: the queue holds the bytes at win_pc onward, pend marks a read in flight.
    byte unsigned mq[$];
    bit           m_pend;
    logic [15:0]  m_pend_addr;
    logic [15:0]  m_fetch;
    logic [15:0]  m_winpc;
    logic [15:0]  m_flushed;
    bit           m_terr;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic r, input logic rd, input logic [15:0] rpc, input logic [1:0] tl);
        reset       = r;
        redirect    = rd;
        redirect_pc = rpc;
        take_len    = tl;
        #1;
    endtask

    task automatic checkOutput();
        int  sz;
        bit  exp_req;
        int  winc;
        sz      = mq.size();
        exp_req = !reset && !redirect && ((sz + int'(m_pend)) < DEPTH);
        winc    = (sz > 3) ? 3 : sz;
        check("mem_req", mem_req, exp_req);
        if (exp_req) check("mem_addr", mem_addr, m_fetch);
        check("win_count", win_count, winc);
        check("win_pc", win_pc, m_winpc);
        check("win_b0", win_b0, (sz > 0) ? mq[0] : 8'h00);
        check("win_b1", win_b1, (sz > 1) ? mq[1] : 8'h00);
        check("win_b2", win_b2, (sz > 2) ? mq[2] : 8'h00);
        check("take_err", take_err, m_terr);
`ifdef FETCH_FLUSH_STATS_EN
        check("flushed", flushed, m_flushed);
`else
        check("flushed", flushed, 16'h0000);
`endif
    endtask

    task automatic modelUpdate();
        int sz;
        int avail;
        int s;
        bit req;
        sz = mq.size();
        if (reset) begin
            mq.delete();
            m_pend    = 0;
            m_fetch   = 16'h0000;
            m_winpc   = 16'h0000;
            m_flushed = 16'h0000;
            m_terr    = 0;
        end else if (redirect) begin
            s = int'(m_flushed) + sz + int'(m_pend);
            m_flushed = (s > 65535) ? 16'hFFFF : 16'(s);
            mq.delete();
            m_pend  = 0;
            m_fetch = redirect_pc;
            m_winpc = redirect_pc;
            m_terr  = 0;
        end else begin
            req   = (sz + int'(m_pend)) < DEPTH;
            avail = (sz > 3) ? 3 : sz;
            if (m_pend) mq.push_back(mem[m_pend_addr]);
            if (int'(take_len) <= avail) begin
                for (int i = 0; i < int'(take_len); i++) void'(mq.pop_front());
                m_winpc = m_winpc + 16'(take_len);
                m_terr  = 0;
            end else begin
                m_terr = 1;
            end
            m_pend      = req;
            m_pend_addr = m_fetch;
            if (req) m_fetch = m_fetch + 16'd1;
        end
    endtask

    task automatic advance();
        @(posedge clk);
        modelUpdate();
        @(negedge clk);
    endtask

    task automatic applyStimulus(input logic r, input logic rd, input logic [15:0] rpc, input logic [1:0] tl);
        drive(r, rd, rpc, tl);
        checkOutput();
        advance();
    endtask

    typedef struct {
        logic [1:0]  take;
        logic        req;
        logic [15:0] addr;
        logic [1:0]  winc;
        logic [15:0] pc;
        logic [7:0]  b0, b1, b2;
    } vec_t;

    vec_t vecs[9];

    initial begin
        logic [15:0] rpc;
        bit          rd;
        bit          r;

        vecs[0] = '{2'd0, 1'b1, 16'h0000, 2'd0, 16'h0000, 8'h00, 8'h00, 8'h00};
        vecs[1] = '{2'd0, 1'b1, 16'h0001, 2'd0, 16'h0000, 8'h00, 8'h00, 8'h00};
        vecs[2] = '{2'd0, 1'b1, 16'h0002, 2'd1, 16'h0000, 8'hA2, 8'h00, 8'h00};
        vecs[3] = '{2'd0, 1'b1, 16'h0003, 2'd2, 16'h0000, 8'hA2, 8'h05, 8'h00};
        vecs[4] = '{2'd0, 1'b0, 16'h0004, 2'd3, 16'h0000, 8'hA2, 8'h05, 8'hE8};
        vecs[5] = '{2'd0, 1'b0, 16'h0004, 2'd3, 16'h0000, 8'hA2, 8'h05, 8'hE8};
        vecs[6] = '{2'd2, 1'b0, 16'h0004, 2'd3, 16'h0000, 8'hA2, 8'h05, 8'hE8};
        vecs[7] = '{2'd1, 1'b1, 16'h0004, 2'd2, 16'h0002, 8'hE8, 8'h4C, 8'h00};
        vecs[8] = '{2'd0, 1'b1, 16'h0005, 2'd1, 16'h0003, 8'h4C, 8'h00, 8'h00};

        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        mem[0] = 8'hA2; mem[1] = 8'h05; mem[2] = 8'hE8;
        mem[3] = 8'h4C; mem[4] = 8'h00; mem[5] = 8'h00;
        mem[16'h0100] = 8'hEA;
        take_len2 = 2'd0;

        @(negedge clk);
        drive(1'b1, 1'b0, 16'h0000, 2'd0);
        advance();
        applyStimulus(1'b1, 1'b0, 16'h0000, 2'd0);

        // Fill from reset, then take 2 and 1.
        for (int i = 0; i < 9; i++) begin
            drive(1'b0, 1'b0, 16'h0000, vecs[i].take);
            checkOutput();
            check($sformatf("vec%0d_req", i), mem_req, vecs[i].req);
            if (vecs[i].req) check($sformatf("vec%0d_addr", i), mem_addr, vecs[i].addr);
            check($sformatf("vec%0d_winc", i), win_count, vecs[i].winc);
            check($sformatf("vec%0d_pc", i), win_pc, vecs[i].pc);
            check($sformatf("vec%0d_b0", i), win_b0, vecs[i].b0);
            check($sformatf("vec%0d_b1", i), win_b1, vecs[i].b1);
            check($sformatf("vec%0d_b2", i), win_b2, vecs[i].b2);
            advance();
        end

        // Illegal take while only one byte is visible.
        applyStimulus(1'b1, 1'b0, 16'h0000, 2'd0);
        applyStimulus(1'b0, 1'b0, 16'h0000, 2'd0);
        applyStimulus(1'b0, 1'b0, 16'h0000, 2'd0);
        drive(1'b0, 1'b0, 16'h0000, 2'd3);
        checkOutput();
        check("err_pre_winc", win_count, 2'd1);
        advance();
        drive(1'b0, 1'b0, 16'h0000, 2'd0);
        checkOutput();
        check("err_pulse", take_err, 1'b1);
        check("err_pc_kept", win_pc, 16'h0000);
        check("err_b0_kept", win_b0, 8'hA2);
        check("err_winc", win_count, 2'd2);
        advance();
        drive(1'b0, 1'b0, 16'h0000, 2'd0);
        checkOutput();
        check("err_pulse_end", take_err, 1'b0);
        advance();

        // Redirect from a full queue with nothing in flight.
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 16'h0000, 2'd0);
        drive(1'b0, 1'b1, 16'h0100, 2'd2);
        checkOutput();
        check("redir_noreq", mem_req, 1'b0);
        advance();
        drive(1'b0, 1'b0, 16'h0000, 2'd0);
        checkOutput();
        check("redir_winc", win_count, 2'd0);
        check("redir_pc", win_pc, 16'h0100);
        check("redir_addr", mem_addr, 16'h0100);
        check("redir_req", mem_req, 1'b1);
        check("redir_noerr", take_err, 1'b0);
`ifdef FETCH_FLUSH_STATS_EN
        check("redir_flushed", flushed, 16'd4);
`endif
        advance();
        applyStimulus(1'b0, 1'b0, 16'h0000, 2'd0);
        drive(1'b0, 1'b0, 16'h0000, 2'd0);
        checkOutput();
        check("redir_b0", win_b0, 8'hEA);
        advance();
        applyStimulus(1'b0, 1'b0, 16'h0000, 2'd1);

        // Reset together with take and redirect.
        drive(1'b1, 1'b1, 16'h1234, 2'd1);
        checkOutput();
        check("rst_noreq", mem_req, 1'b0);
        advance();
        drive(1'b0, 1'b0, 16'h0000, 2'd0);
        checkOutput();
        check("rst_pc", win_pc, 16'h0000);
        check("rst_winc", win_count, 2'd0);
        check("rst_b0", win_b0, 8'h00);
        check("rst_terr", take_err, 1'b0);
        check("rst_flushed", flushed, 16'h0000);
        advance();

        // Wrap-around fill on the instance reset to FFFE.
        for (int i = 0; i < 20 && win_count2 != 2'd3; i++) applyStimulus(1'b0, 1'b0, 16'h0000, 2'd0);
        check("wrap_fill", win_count2, 2'd3);
        check("wrap_pc", win_pc2, 16'hFFFE);
        check("wrap_b0", win2_b0, 8'h11);
        check("wrap_b1", win2_b1, 8'h22);
        check("wrap_b2", win2_b2, 8'h33);
        take_len2 = 2'd2;
        applyStimulus(1'b0, 1'b0, 16'h0000, 2'd0);
        take_len2 = 2'd0;
        #1;
        check("wrap_pc_after", win_pc2, 16'h0000);

        // Randomized traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            r   = ($urandom_range(0, 199) == 0);
            rd  = ($urandom_range(0, 14) == 0);
            rpc = ($urandom_range(0, 3) == 0) ? (16'hFFFC | 16'($urandom_range(0, 3))) : 16'($urandom);
            applyStimulus(r, rd, rpc, 2'($urandom_range(0, 3)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
